// File: rtl/shift_pkg.sv
// Shared types for the sequential shift unit.
//   shift_op_t : 2-bit shift operation code (SLL/SRL/SRA/RSVD).
//   state_t    : control FSM state encoding.
`timescale 1ns/1ps
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_RSVD = 2'b11   // treated exactly as SLL
  } shift_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shifter.
// Ports:
//   data   in  32  operand
//   op     in  2   shift_op_t
//   result out 32  operand shifted by exactly one position
`timescale 1ns/1ps
module shift_step
  import shift_pkg::*;
(
  input  logic [31:0] data,
  input  shift_op_t   op,
  output logic [31:0] result
);

  always_comb begin
    result = {data[30:0], 1'b0};
    case (op)
      OP_SRL:  result = {1'b0, data[31:1]};
      // Re-inserting bit 31 each step smears the original MSB across
      // every vacated position over successive steps.
      OP_SRA:  result = {data[31], data[31:1]};
      default: result = {data[30:0], 1'b0};  // SLL and reserved
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Sequential shift unit: shifts one bit position per clock.
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   upstream offers an operation
//   in_ready   out  1   high only in IDLE
//   in_data    in   32  operand
//   in_shamt   in   5   shift amount 0..31
//   in_op      in   2   shift_op_t
//   out_valid  out  1   result presented (DONE state)
//   out_ready  in   1   downstream accepts result
//   out_data   out  32  data register
//   busy       out  1   high whenever not IDLE
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both high. in_ready does not depend on in_valid; out_valid
// does not depend on out_ready. Once raised, out_valid and out_data hold
// until the transfer completes.
`timescale 1ns/1ps
module shift_unit_seq
  import shift_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_shamt,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  state_t      state;
  logic [31:0] data_q;
  logic [4:0]  cnt_q;
  shift_op_t   op_q;
  logic [31:0] step_data;

  shift_step u_step (
    .data   (data_q),
    .op     (op_q),
    .result (step_data)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      data_q <= '0;
      cnt_q  <= '0;
      op_q   <= OP_SLL;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            op_q   <= shift_op_t'(in_op);
            cnt_q  <= in_shamt;
            state  <= (in_shamt == 5'd0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          data_q <= step_data;
          cnt_q  <= cnt_q - 5'd1;
          // cnt_q == 1 means this edge performs the last shift.
          if (cnt_q == 5'd1) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Randomized bench for shift_unit_seq with a scoreboard and monitor.
`timescale 1ns/1ps
module tb_shift_unit_seq;
  import shift_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  shift_unit_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          hold_left = 0;

  task automatic check_eq(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-word arithmetic shift semantics.
  function automatic logic [31:0] model(input logic [31:0] d,
                                        input int sh, input logic [1:0] op);
    case (op)
      2'b01:   return d >> sh;
      2'b10:   return 32'($signed(d) >>> sh);
      default: return d << sh;
    endcase
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic wait_ready();
    int waited = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic issue(input logic [31:0] d, input logic [4:0] sh,
                       input logic [1:0] op);
    wait_ready();
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 at t=%0t", $time);
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_op    = op;
    exp_q.push_back(model(d, int'(sh), op));
    lat_q.push_back(edge_cnt + 1 + int'(sh));
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_shamt = 5'($urandom);
    in_op    = 2'($urandom);
  endtask

  // ---------------- monitor ----------------
  initial begin
    bit          prev_v = 1'b0;
    bit          hs_prev = 1'b0;
    logic [31:0] cur_exp = '0;
    int          exp_lat;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v  = 1'b0;
        hs_prev = 1'b0;
        out_ready = 1'b0;
        continue;
      end
      if (hs_prev) begin
        check_eq("in_ready_after_hs", 32'(in_ready), 32'd1);
        check_eq("valid_drop_after_hs", 32'(out_valid), 32'd0);
      end
      if (out_valid) begin
        if (!prev_v) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_valid: got out_valid=1 data=%h expected no result", out_data);
          end else begin
            cur_exp = exp_q.pop_front();
            exp_lat = lat_q.pop_front();
            check_eq("latency_edge", 32'(edge_cnt), 32'(exp_lat));
          end
        end
        check_eq("out_data", out_data, cur_exp);
        check_eq("in_ready_in_done", 32'(in_ready), 32'd0);
        check_eq("busy_in_done", 32'(busy), 32'd1);
        if (hold_left > 0) begin
          out_ready = 1'b0;
          hold_left--;
        end else begin
          out_ready = ($urandom_range(0, 3) != 0);
        end
        hs_prev = out_ready;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        hs_prev   = 1'b0;
      end
      prev_v = out_valid;
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    int waited;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    // Issued in the release cycle: accept must happen on the first edge.
    issue(32'hE000_0000, 5'd3, 2'b10);
    issue(32'hE000_0000, 5'd3, 2'b00);
    issue(32'h0000_0001, 5'd31, 2'b00);
    issue(32'h8000_0001, 5'd31, 2'b01);
    issue(32'h8000_0000, 5'd31, 2'b10);
    for (int o = 0; o < 4; o++) issue($urandom, 5'd0, 2'(o));
    issue(32'hA5A5_0F0F, 5'd7, 2'b11);

    // Backpressure: five cycles of out_ready low with in_valid noise.
    wait_ready();
    hold_left = 5;
    issue(32'h1234_5678, 5'd2, 2'b01);
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_eq("bp_reach_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_shamt = 5'd0;
      in_op    = 2'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;

    // Reset in the middle of a shamt-10 operation.
    wait_ready();
    issue($urandom, 5'd10, 2'b10);
    check_eq("busy_in_shift", 32'(busy), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("async_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    check_eq("async_rst_out_data", out_data, 32'd0);
    exp_q.delete();
    lat_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    issue(32'hF0F0_0001, 5'd4, 2'b01);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      logic [4:0] sh;
      sh = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 1)) : 5'($urandom);
      issue($urandom, sh, 2'($urandom_range(0, 3)));
    end

    waited = 0;
    while ((exp_q.size() != 0 || out_valid) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_unit_seq.md
SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

Interface
REQ-001 SHALL declare ports in this order, one per line: name  direction  width  meaning.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream offers an operation.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 in_data  input  32  operand to shift.
REQ-007 in_shamt  input  5  shift amount, 0..31.
REQ-008 in_op  input  2  shift_op_t: 2'b00 SLL, 2'b01 SRL, 2'b10 SRA, 2'b11 reserved.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  32  shifted result.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 SHALL drive in_ready high only in IDLE; the handshake completes on a clk edge with in_valid && in_ready.
REQ-015 On accept, SHALL capture in_data into the data register, in_op into the op register, and in_shamt into a 5-bit down-counter.
REQ-016 On accept with in_shamt == 0, SHALL go IDLE -> DONE; otherwise IDLE -> SHIFT.
REQ-017 In SHIFT, SHALL shift the data register by exactly one position per cycle and decrement the counter.
REQ-018 In SHIFT, SHALL go SHIFT -> DONE on the cycle that performs the final shift (counter == 1).
REQ-019 Latency SHALL be: accept in cycle T -> out_valid first high in cycle T+1+shamt.
REQ-020 SLL SHALL fill with 0 at bit 0; SRL SHALL fill with 0 at bit 31; SRA SHALL replicate bit 31 into bit 31 at every step, so the original MSB fills all vacated positions.
REQ-021 Reserved op 2'b11 SHALL behave exactly as SLL.
REQ-022 In DONE, SHALL hold out_valid high and out_data stable until out_ready is sampled high.
REQ-023 On DONE with out_ready high, SHALL go DONE -> IDLE; the next accept is possible no earlier than the following cycle (no same-cycle turnaround).
REQ-024 out_valid SHALL be low outside DONE.
REQ-025 out_data SHALL equal the data register at all times; its value is don't-care when out_valid is low.
REQ-026 in_valid, in_data, in_shamt and in_op SHALL be ignored outside IDLE.
REQ-027 out_ready SHALL be ignored outside DONE.

Reset
REQ-028 While rst_n is low, SHALL force: state IDLE, data register 0, counter 0, op register SLL; hence out_valid=0, out_data=0, busy=0, in_ready=1.
REQ-029 Assertion of rst_n in SHIFT or DONE SHALL abort the operation immediately; the result is lost and no out_valid is produced for it.
REQ-030 On rst_n deassertion, SHALL be able to accept on the first rising clk edge.

Structure
REQ-031 SHALL place shift_op_t (2-bit enum SLL/SRL/SRA/RSVD) and the state enum in a package named shift_pkg, imported by the module and the bench.
REQ-032 SHALL implement the one-position shift as a combinational sub-module shift_step (inputs: 32-bit data, op; output: 32-bit data), instantiated once.
REQ-033 SHALL use no multi-bit shift operators in the datapath; shift_step is the only shift logic.

Verification
REQ-034 SRA, in_data 32'hE000_0000, shamt 3, accepted cycle T -> out_valid in cycle T+4, out_data 32'hFC00_0000.
REQ-035 SLL, in_data 32'hE000_0000, shamt 3 -> out_data 32'h0000_0000; SLL, 32'h0000_0001, shamt 31 -> 32'h8000_0000 in cycle T+32.
REQ-036 SRL, 32'h8000_0001, shamt 31 -> 32'h0000_0001; SRA, 32'h8000_0000, shamt 31 -> 32'hFFFF_FFFF; shamt 0 with any op -> out_data equals in_data in cycle T+1.
REQ-037 Backpressure: hold out_ready low 5 cycles in DONE -> out_valid and out_data stable, in_ready low, later in_valid pulses ignored; after the out_ready handshake, in_ready rises the next cycle.
REQ-038 Reset mid-operation: drop rst_n in cycle T+2 of a shamt-10 operation -> outputs match REQ-028 asynchronously; no out_valid follows; a new op accepted after release completes correctly.
